// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, receiver state encoding and parity helper
package uart_pkg;
   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} uart_rx_state_e;
   function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data, input logic odd);
      return ^data ^ odd;
   endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input, with a selectable reset level
module uart_sync2 #(
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic m;
   always_ff @(posedge clk)
      if (reset) {q, m} <= {2{RESET_VAL}};
      else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: mid-bit sampling receiver for start/8 data/parity/stop frames
module uart_rx_frame import uart_pkg::*; #(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_en,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_ready,
   output logic       parity_error,
   output logic       stop_error
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   uart_rx_state_e state, state_n;
   logic rx_s, sample, fin;
   logic [CW-1:0] cnt;
   logic [2:0] nbit;
   logic [UART_DATA_BITS-1:0] sh;
   logic perr;
   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d(rx), .q(rx_s));
   assign sample = cnt == MID;
   assign fin = state == STOP && sample && nbit == 3'(UART_STOP_BITS - 1) && rx_en;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:      state_n = (rx_en && !rx_s) ? START : IDLE;
         START:     state_n = !sample ? START : rx_s ? IDLE : DATA;
         DATA:      state_n = (sample && nbit == 3'(UART_DATA_BITS - 1)) ? PARITY : DATA;
         PARITY:    state_n = sample ? STOP : PARITY;
         STOP:      state_n = !(sample && nbit == 3'(UART_STOP_BITS - 1)) ? STOP : rx_s ? IDLE : WAIT_HIGH;
         WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
         default:   state_n = IDLE;
      endcase
      if (!rx_en && state != IDLE) state_n = IDLE;
   end
   always_ff @(posedge clk) begin
      data_ready <= 1'b0;
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         nbit         <= '0;
         sh           <= '0;
         perr         <= 1'b0;
         data_out     <= '0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= (state == IDLE || cnt == LAST) ? '0 : cnt + 1'b1;
         if (state == START) nbit <= '0;
         if ((state == DATA || state == STOP) && sample) nbit <= nbit + 3'd1;
         if (state == DATA && sample) sh <= {rx_s, sh[UART_DATA_BITS-1:1]};
         if (state == PARITY && sample) perr <= rx_s != uart_parity(sh, PARITY_ODD);
         if (fin) begin
            data_out     <= sh;
            parity_error <= perr;
            stop_error   <= !rx_s;
            data_ready   <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: table, directed and random frame checks against a frame-level model
module tb_uart_rx_frame;
   localparam int BIT = 16;
   localparam int LAT = 171;
   typedef struct {logic [7:0] d; logic p; logic s; logic [7:0] xd; logic xpe; logic xse;} vec_t;
   typedef struct {logic [7:0] d; logic pe; logic se; int cyc;} obs_t;
   logic clk = 1'b0, reset = 1'b1, rx_en = 1'b1, rx = 1'b1;
   logic [7:0] data_out;
   logic data_ready, parity_error, stop_error;
   int cyc = 0, checks = 0, errors = 0, t0 = 0;
   obs_t q[$];
   obs_t mon;
   logic [7:0] md = 8'h00;
   logic mpe = 1'b0, mse = 1'b0;
   uart_rx_frame #(.CLKS_PER_BIT(BIT), .PARITY_ODD(1'b0)) dut (
      .clk(clk), .reset(reset), .rx_en(rx_en), .rx(rx),
      .data_out(data_out), .data_ready(data_ready),
      .parity_error(parity_error), .stop_error(stop_error)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      #2;
      if (data_ready) begin
         mon = '{data_out, parity_error, stop_error, cyc};
         q.push_back(mon);
      end
   end
   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask
   task automatic chk_held(input string name);
      chk({name, "_data"}, data_out, md);
      chk({name, "_pe"}, parity_error, mpe);
      chk({name, "_se"}, stop_error, mse);
   endtask
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int hold);
      logic [10:0] f;
      f = {s, p, d, 1'b0};
      t0 = cyc;
      for (int i = 0; i < 11; i++) begin
         rx = f[i];
         repeat (i == 10 ? BIT + hold : BIT) @(negedge clk);
      end
      rx = 1'b1;
   endtask
   task automatic expect_frame(input string name, input logic [7:0] xd, input logic xpe, input logic xse,
                               input bit solo, output int pc);
      obs_t o;
      int w;
      w = 0;
      pc = 0;
      while (q.size() == 0 && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_ready: no data_ready pulse seen, expected one", name);
         return;
      end
      o = q.pop_front();
      pc = o.cyc;
      md = xd;
      mpe = xpe;
      mse = xse;
      chk({name, "_data"}, o.d, xd);
      chk({name, "_pe"}, o.pe, xpe);
      chk({name, "_se"}, o.se, xse);
      if (solo) begin
         repeat (3) @(negedge clk);
         chk({name, "_single_pulse"}, q.size(), 0);
      end
   endtask
   initial begin
      vec_t tbl[8];
      int pc, pc2, gap;
      logic [7:0] d;
      logic p, s, xpe;
      tbl = '{
         '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0},
         '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0},
         '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0},
         '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0},
         '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0},
         '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0},
         '{8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1},
         '{8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1}
      };
      repeat (3) @(negedge clk);
      chk("reset_ready", data_ready, 1'b0);
      chk_held("reset");
      reset = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         send_frame(tbl[i].d, tbl[i].p, tbl[i].s, 0);
         expect_frame($sformatf("tbl%0d", i), tbl[i].xd, tbl[i].xpe, tbl[i].xse, 1'b1, pc);
         chk($sformatf("tbl%0d_latency", i), pc - t0, LAT);
         repeat (4) @(negedge clk);
      end
      send_frame(8'h81, 1'b0, 1'b0, 40);
      expect_frame("break81", 8'h81, 1'b0, 1'b1, 1'b1, pc);
      repeat (4) @(negedge clk);
      send_frame(8'h7E, 1'b0, 1'b1, 0);
      expect_frame("after_break7E", 8'h7E, 1'b0, 1'b0, 1'b1, pc);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_no_ready", q.size(), 0);
      chk_held("glitch_hold");
      fork
         send_frame(8'h55, 1'b0, 1'b1, 0);
         begin
            repeat (4 * BIT + 8) @(negedge clk);
            rx_en = 1'b0;
         end
      join
      repeat (4) @(negedge clk);
      rx_en = 1'b1;
      repeat (10) @(negedge clk);
      chk("abort_no_ready", q.size(), 0);
      chk_held("abort_hold");
      send_frame(8'h55, 1'b1, 1'b0, 0);
      expect_frame("err55", 8'h55, 1'b1, 1'b1, 1'b1, pc);
      repeat (4) @(negedge clk);
      fork
         send_frame(8'h55, 1'b0, 1'b1, 0);
         begin
            repeat (4 * BIT + 8) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            md = 8'h00;
            mpe = 1'b0;
            mse = 1'b0;
            chk("midreset_ready", data_ready, 1'b0);
            chk_held("midreset");
         end
      join
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("midreset_no_ready", q.size(), 0);
      chk_held("after_reset");
      send_frame(8'h00, 1'b0, 1'b1, 0);
      send_frame(8'hFF, 1'b0, 1'b1, 0);
      expect_frame("b2b_00", 8'h00, 1'b0, 1'b0, 1'b0, pc);
      expect_frame("b2b_FF", 8'hFF, 1'b0, 1'b0, 1'b1, pc2);
      chk("b2b_spacing", pc2 - pc, 176);
      for (int i = 0; i < 30; i++) begin
         d = 8'($urandom_range(0, 255));
         p = 1'($countones(d) % 2) ^ ($urandom_range(0, 3) == 0);
         s = $urandom_range(0, 4) != 0;
         xpe = p != 1'($countones(d) % 2);
         gap = $urandom_range(2, 12);
         send_frame(d, p, s, 0);
         expect_frame($sformatf("rnd%0d", i), d, xpe, !s, 1'b1, pc);
         chk($sformatf("rnd%0d_latency", i), pc - t0, LAT);
         repeat (gap) @(negedge clk);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
